si53xx_config_sequencer: RTL
============================

Name: si53xx_config_sequencer

Overview:
Upstream command source for si53xx_spi_interface. Walks a register-map ROM of 16-bit entries and issues one single-byte SPI write per entry, executing embedded delay and end markers. After the map completes, it polls the PLL status register until the loss-of-lock bits clear or a try limit expires. All SPI traffic uses a one-request/one-done handshake with the interface.

Parameters:
ROM_AW, 10, ROM address width; the map holds at most 2**ROM_AW entries.
CLKS_PER_MS, 100000, clk cycles per delay unit (1 ms at 100 MHz).
STATUS_ADDR, 8'h0E, status register polled after the map.
STATUS_MASK, 8'h0A, status bits that must all read 0 for lock.
POLL_GAP_MS, 10, delay units between status reads.
POLL_MAX, 100, maximum number of status reads before error.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a sequence when idle
rom_addr  out  ROM_AW  ROM entry index
rom_data  in  16  entry: [15:8] register address, [7:0] data; ROM has registered output, 1-cycle latency
spi_write  out  1  one-cycle write request
spi_read  out  1  one-cycle read request
spi_addr  out  8  register address; held stable from request until done
spi_wdata  out  8  write data; held stable from request until done
spi_rdata  in  8  read data; valid in the cycle spi_done is high
spi_done  in  1  one-cycle pulse; transaction complete
busy  out  1  high from accepted start until DONE or ERR
done  out  1  sticky; map loaded and lock achieved
error  out  1  sticky; poll timeout or missing end marker
poll_count  out  8  status reads issued; saturates at 255

Behaviour:
- Reset (synchronous, active-high) overrides everything. Next cycle: state IDLE, all outputs 0, rom_addr 0, counters 0.
- Reset mid-transaction abandons the sequence. A later spi_done is ignored.
- Entry markers:
  - Address 8'hFE: delay of data×CLKS_PER_MS cycles; data 0 means no delay.
  - Address 8'hFF: end of map.
  - Any other address: SPI write of data to that address.
- IDLE: start=1 → clear done/error/poll_count, rom_addr←0, busy←1 → FETCH. start is ignored in every other state.
- FETCH: wait 1 cycle for ROM latency → DECODE.
- DECODE:
  - Write entry: load spi_addr/spi_wdata, pulse spi_write for exactly one cycle → WAIT_WR.
  - 8'hFE: load the delay counter → DELAY.
  - 8'hFF → POLL_PG.
- WAIT_WR: hold spi_addr/spi_wdata until spi_done, then → NEXT.
- DELAY: count down, then → NEXT.
- NEXT:
  - If rom_addr == 2**ROM_AW−1 (no end marker found) → ERR.
  - Otherwise rom_addr+1 → FETCH.
- POLL_PG: write 8'h00 to page register 8'h01 (one spi_write, wait spi_done) → POLL_RD.
- POLL_RD: pulse spi_read with spi_addr=STATUS_ADDR; poll_count+1 (saturating) → WAIT_RD.
- WAIT_RD, on spi_done:
  - (spi_rdata & STATUS_MASK)==0 → DONE.
  - Else, if reads issued == POLL_MAX → ERR.
  - Else → POLL_GAP.
- POLL_GAP: wait POLL_GAP_MS×CLKS_PER_MS cycles → POLL_RD.
- DONE: done=1, busy=0; stays until start or reset. start restarts the sequence.
- ERR: error=1, busy=0; stays until start or reset. start restarts the sequence.
- spi_write and spi_read are never high together and never re-asserted before the matching spi_done.
- spi_done outside WAIT_WR/WAIT_RD is ignored.
- Delay counter is 32 bits; the data×CLKS_PER_MS product must not truncate for data=255.

Test Plan:
1. ROM {0x0B24, 0x0102, 0xFF00}, start → writes (0x0B,0x24) then (0x01,0x02); page write (0x01,0x00); read 0x0E; rdata 0x00 → done=1, busy=0, poll_count=1.
2. CLKS_PER_MS=10, ROM {0xFE03, 0x1234, 0xFF00} → exactly 30 clk (±2 fixed overhead) between FE decode and spi_write for 0x12; data 0x34.
3. Status returns 0x02 three times, then 0x00; POLL_GAP_MS=1 → 4 reads, poll_count=4, done=1, gap ≥ CLKS_PER_MS cycles between reads.
4. POLL_MAX=5, status always 0x08 → exactly 5 reads, then error=1, done=0, busy=0.
5. ROM_AW=2, no 0xFF entry → 4 writes, then error=1, no read issued.
6. Reset asserted in WAIT_WR, spi_done arrives 3 cycles later → all outputs 0, state IDLE; a new start runs the full sequence from rom_addr 0. start pulsed while busy → no effect.

Source files
------------

// File: rtl/si53xx_config_sequencer_if.sv
// Request/done command channel between the config sequencer and the SPI interface.
interface si53xx_config_sequencer_if;
    logic       spi_write;
    logic       spi_read;
    logic [7:0] spi_addr;
    logic [7:0] spi_wdata;
    logic [7:0] spi_rdata;
    logic       spi_done;

    modport master (
        output spi_write, spi_read, spi_addr, spi_wdata,
        input  spi_rdata, spi_done
    );

    modport slave (
        input  spi_write, spi_read, spi_addr, spi_wdata,
        output spi_rdata, spi_done
    );
endinterface

// File: rtl/si53xx_config_sequencer.sv
// Walks a register-map ROM issuing SPI writes, honours delay/end markers,
// then polls the PLL status register until lock or a retry limit.
module si53xx_config_sequencer #(
    parameter int unsigned ROM_AW      = 10,
    parameter int unsigned CLKS_PER_MS = 100000,
    parameter logic [7:0]  STATUS_ADDR = 8'h0E,
    parameter logic [7:0]  STATUS_MASK = 8'h0A,
    parameter int unsigned POLL_GAP_MS = 10,
    parameter int unsigned POLL_MAX    = 100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [15:0]               rom_data,
    si53xx_config_sequencer_if.master spi,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [7:0]                poll_count
);
    localparam logic [7:0]  DELAY_MARK = 8'hFE;
    localparam logic [7:0]  END_MARK   = 8'hFF;
    localparam logic [7:0]  PAGE_ADDR  = 8'h01;
    localparam logic [31:0] GAP_CYCLES = 32'(POLL_GAP_MS * CLKS_PER_MS);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT_WR, S_DELAY, S_NEXT, S_POLL_PG,
        S_WAIT_PG, S_POLL_RD, S_WAIT_RD, S_POLL_GAP, S_DONE, S_ERR
    } state_t;

    state_t      state;
    logic [31:0] delay_cnt;
    logic [31:0] reads;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            rom_addr      <= '0;
            spi.spi_write <= 1'b0;
            spi.spi_read  <= 1'b0;
            spi.spi_addr  <= '0;
            spi.spi_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            poll_count    <= '0;
            delay_cnt     <= '0;
            reads         <= '0;
        end else begin
            spi.spi_write <= 1'b0;
            spi.spi_read  <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        poll_count <= '0;
                        reads      <= '0;
                        rom_addr   <= '0;
                        busy       <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (rom_data[15:8])
                        END_MARK: state <= S_POLL_PG;
                        DELAY_MARK: begin
                            // Zero-length delay skips the DELAY state entirely.
                            if (rom_data[7:0] == 8'd0) begin
                                state <= S_NEXT;
                            end else begin
                                delay_cnt <= 32'(rom_data[7:0]) * CLKS_PER_MS;
                                state     <= S_DELAY;
                            end
                        end
                        default: begin
                            spi.spi_addr  <= rom_data[15:8];
                            spi.spi_wdata <= rom_data[7:0];
                            spi.spi_write <= 1'b1;
                            state         <= S_WAIT_WR;
                        end
                    endcase
                end
                S_WAIT_WR: if (spi.spi_done) state <= S_NEXT;
                S_DELAY: begin
                    if (delay_cnt <= 32'd1) state <= S_NEXT;
                    else delay_cnt <= delay_cnt - 32'd1;
                end
                S_NEXT: begin
                    if (rom_addr == '1) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= S_FETCH;
                    end
                end
                S_POLL_PG: begin
                    spi.spi_addr  <= PAGE_ADDR;
                    spi.spi_wdata <= 8'h00;
                    spi.spi_write <= 1'b1;
                    state         <= S_WAIT_PG;
                end
                S_WAIT_PG: if (spi.spi_done) state <= S_POLL_RD;
                S_POLL_RD: begin
                    spi.spi_addr <= STATUS_ADDR;
                    spi.spi_read <= 1'b1;
                    reads        <= reads + 32'd1;
                    if (poll_count != 8'hFF) poll_count <= poll_count + 8'd1;
                    state        <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (spi.spi_done) begin
                        if ((spi.spi_rdata & STATUS_MASK) == 8'h00) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if (reads >= POLL_MAX) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERR;
                        end else if (GAP_CYCLES == 32'd0) begin
                            state <= S_POLL_RD;
                        end else begin
                            delay_cnt <= GAP_CYCLES;
                            state     <= S_POLL_GAP;
                        end
                    end
                end
                S_POLL_GAP: begin
                    if (delay_cnt <= 32'd1) state <= S_POLL_RD;
                    else delay_cnt <= delay_cnt - 32'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
